// File: rtl/cache_pkg.sv
// Shared request-tracking types for the cache and its memory responder.
// Entry fields are sized for the widest user; each side casts to its own widths.
package cache_pkg;

   localparam int CACHE_ID_W = 2;
   localparam int PEND_ID_W  = 8;
   localparam int PEND_PA_W  = 64;
   localparam int PEND_CD_W  = 8;

   typedef struct packed {
      logic [PEND_ID_W-1:0] id;
      logic [PEND_PA_W-1:0] line_addr;
      logic [PEND_CD_W-1:0] countdown;
   } pend_t;

endpackage

// File: rtl/mem_responder_rsp_queue.sv
// Circular queue of pending line reads; every entry counts down to readiness.
// Responses leave strictly from the head, so ordering follows acceptance.
module rsp_queue
   import cache_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  pend_t push_entry,
   input  logic  pop,
   output pend_t head,
   output logic  head_ready,
   output logic  full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   pend_t            entries [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Fullness is judged before this cycle's pop, so a pop never makes room for a same-cycle push.
   assign full       = (count == CNT_W'(DEPTH));
   assign head       = entries[rd_ptr];
   assign head_ready = (count != '0) && (head.countdown == '0);
   assign do_push    = push && !full;
   assign do_pop     = pop && head_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (do_push && (wr_ptr == PTR_W'(i)))
            entries[i] <= push_entry;
         else if (entries[i].countdown != '0)
            entries[i].countdown <= entries[i].countdown - PEND_CD_W'(1);
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Simulated backing memory: word stores land immediately, line reads return
// in order after a fixed latency and are held until the requester acks.
module mem_responder
   import cache_pkg::*;
#(
   parameter int REG_WIDTH   = 32,
   parameter int PA_WIDTH    = 32,
   parameter int LINE_BYTES  = 16,
   parameter int ID_WIDTH    = CACHE_ID_W,
   parameter int MEM_BYTES   = 4096,
   parameter int LATENCY     = 4,
   parameter int QUEUE_LINES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_enable,
   input  logic [PA_WIDTH-1:0]       i_addr,
   input  logic [REG_WIDTH-1:0]      i_data,
   input  logic                      i_write,
   input  logic                      i_ack,
   output logic                      o_busy,
   output logic                      o_enable,
   output logic [LINE_BYTES*8-1:0]   o_data,
   output logic [ID_WIDTH-1:0]       o_id_request,
   output logic [ID_WIDTH-1:0]       o_id_response
);

   localparam int WORD_BYTES = REG_WIDTH / 8;
   localparam int AW         = $clog2(MEM_BYTES);

   logic [7:0]          mem [MEM_BYTES];
   logic [ID_WIDTH-1:0] next_id;
   pend_t               push_entry;
   pend_t               head;
   logic                head_ready;
   logic                full;
   logic                accept;
   logic                push;
   logic [AW-1:0]       wr_base;
   logic [AW-1:0]       rd_base;
   logic [PA_WIDTH-1:0] line_addr;
   logic                unused_head;

   assign accept    = i_enable && !full;
   assign push      = accept && !i_write;
   assign wr_base   = i_addr[AW-1:0] & ~AW'(WORD_BYTES - 1);
   assign line_addr = i_addr & ~PA_WIDTH'(LINE_BYTES - 1);

   always_comb begin
      push_entry           = '0;
      push_entry.id        = PEND_ID_W'(next_id);
      push_entry.line_addr = PEND_PA_W'(line_addr);
      push_entry.countdown = PEND_CD_W'(LATENCY - 1);
   end

   rsp_queue #(
      .DEPTH(QUEUE_LINES)
   ) u_rsp_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (i_ack),
      .head       (head),
      .head_ready (head_ready),
      .full       (full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       next_id <= '0;
      else if (push) next_id <= next_id + ID_WIDTH'(1);
   end

   // Backing store is deliberately left out of reset so data survives a reset pulse.
   always_ff @(posedge clk) begin
      if (accept && i_write) begin
         for (int k = 0; k < WORD_BYTES; k++)
            mem[wr_base + AW'(k)] <= i_data[8*k +: 8];
      end
   end

   assign rd_base = head.line_addr[AW-1:0];

   always_comb begin
      o_data = '0;
      if (head_ready) begin
         for (int k = 0; k < LINE_BYTES; k++)
            o_data[8*k +: 8] = mem[rd_base + AW'(k)];
      end
   end

   assign o_busy        = full;
   assign o_enable      = head_ready;
   assign o_id_request  = next_id;
   assign o_id_response = head_ready ? head.id[ID_WIDTH-1:0] : '0;
   assign unused_head   = ^head;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: store/read latency, ordering, back-pressure,
// ID wrap, held responses and asynchronous reset.
module tb_mem_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_enable = 1'b0;
   logic         i_write = 1'b0;
   logic         i_ack = 1'b0;
   logic [31:0]  i_addr = '0;
   logic [31:0]  i_data = '0;
   logic         o_busy;
   logic         o_enable;
   logic [127:0] o_data;
   logic [1:0]   o_id_request;
   logic [1:0]   o_id_response;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .REG_WIDTH(32), .PA_WIDTH(32), .LINE_BYTES(16), .ID_WIDTH(2),
      .MEM_BYTES(4096), .LATENCY(4), .QUEUE_LINES(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_enable      (i_enable),
      .i_addr        (i_addr),
      .i_data        (i_data),
      .i_write       (i_write),
      .i_ack         (i_ack),
      .o_busy        (o_busy),
      .o_enable      (o_enable),
      .o_data        (o_data),
      .o_id_request  (o_id_request),
      .o_id_response (o_id_response)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      i_enable = 1'b1; i_write = 1'b1; i_addr = a; i_data = d;
      cyc();
      i_enable = 1'b0; i_write = 1'b0;
   endtask

   task automatic read(input logic [31:0] a);
      i_enable = 1'b1; i_write = 1'b0; i_addr = a;
      cyc();
      i_enable = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) cyc();
      check("rst_enable", o_enable, 0);
      check("rst_busy", o_busy, 0);
      check("rst_id_req", o_id_request, 0);
      check("rst_id_rsp", o_id_response, 0);
      check("rst_data", o_data, 0);
      rst = 1'b0;
      cyc();

      // Store then read with latency 4; unaligned store aligns down to 0x108
      store(32'h104, 32'hDEADBEEF);
      store(32'h10B, 32'hCAFEF00D);
      read(32'h10C);
      check("b_id_req", o_id_request, 1);
      i_ack = 1'b1;
      cyc();
      cyc();
      check("b_en_t3", o_enable, 0);
      i_ack = 1'b0;
      cyc();
      check("b_en_t4", o_enable, 1);
      check("b_word1", o_data[63:32], 32'hDEADBEEF);
      check("b_word2", o_data[95:64], 32'hCAFEF00D);
      check("b_id_rsp", o_id_response, 0);
      cyc();
      check("b_held", o_enable, 1);
      i_ack = 1'b1;
      cyc();
      i_ack = 1'b0;
      check("b_popped", o_enable, 0);

      // Reset while two reads are pending
      read(32'h104);
      read(32'h10C);
      check("d_id_req", o_id_request, 3);
      #2 rst = 1'b1;
      #1;
      check("d_rst_en", o_enable, 0);
      check("d_rst_idreq", o_id_request, 0);
      check("d_rst_busy", o_busy, 0);
      cyc();
      rst = 1'b0;
      repeat (6) cyc();
      check("d_discarded", o_enable, 0);
      read(32'h100);
      repeat (3) cyc();
      check("d_en", o_enable, 1);
      check("d_id_rsp", o_id_response, 0);
      check("d_retained", o_data[63:32], 32'hDEADBEEF);
      i_ack = 1'b1;
      cyc();
      i_ack = 1'b0;

      // Store after a read is still seen by the response
      read(32'h200);
      store(32'h200, 32'h12345678);
      cyc();
      check("c_en_t3", o_enable, 0);
      cyc();
      check("c_en_t4", o_enable, 1);
      check("c_id_rsp", o_id_response, 1);
      check("c_data", o_data[31:0], 32'h12345678);
      i_ack = 1'b1;
      cyc();
      i_ack = 1'b0;

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();

      // Fill the queue, refuse extra reads, hold and drain in order
      for (int i = 0; i < 5; i++)
         store(32'h300 + 32'(i) * 32'h10, 32'h11111111 * 32'(i + 1));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("e_id_req%0d", i), o_id_request, i);
         read(32'h300 + 32'(i) * 32'h10);
      end
      check("e_busy", o_busy, 1);
      check("e_id_wrap", o_id_request, 0);
      read(32'h340);
      check("e_busy_refuse", o_busy, 1);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("e_hold_en%0d", i), o_enable, 1);
         check($sformatf("e_hold_id%0d", i), o_id_response, 0);
         check($sformatf("e_hold_d%0d", i), o_data[31:0], 32'h11111111);
         cyc();
      end
      i_ack = 1'b1;
      i_enable = 1'b1; i_write = 1'b0; i_addr = 32'h340;
      cyc();
      i_enable = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check($sformatf("e_en%0d", i), o_enable, 1);
         check($sformatf("e_id%0d", i), o_id_response, i);
         check($sformatf("e_data%0d", i), o_data[31:0], 32'h11111111 * 32'(i + 1));
         check($sformatf("e_busy%0d", i), o_busy, 0);
         cyc();
      end
      i_ack = 1'b0;
      check("e_drained", o_enable, 0);

      // Fifth read after the wrap carries ID 0
      read(32'h340);
      check("f_id_req", o_id_request, 1);
      repeat (2) cyc();
      check("f_en_t3", o_enable, 0);
      cyc();
      check("f_en", o_enable, 1);
      check("f_id_rsp", o_id_response, 0);
      check("f_data", o_data[31:0], 32'h55555555);
      i_ack = 1'b1;
      cyc();
      i_ack = 1'b0;
      check("f_popped", o_enable, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
